// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types and constants for the tone oscillator
package tone_pkg;

    localparam int PHASE_WIDTH  = 32;
    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_sel_t;

    // Symmetric square levels so positive and negative halves have equal magnitude
    localparam logic signed [SAMPLE_WIDTH-1:0] SQUARE_HI = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] SQUARE_LO = {1'b1, {(SAMPLE_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [SAMPLE_WIDTH-1:0]        SIGN_FLIP = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

endpackage

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - maps a phase value to a signed square/saw/triangle sample
module wave_shaper
    import tone_pkg::*;
(
    input  logic [SAMPLE_WIDTH-1:0]        p,
    input  wave_sel_t                      wave_sel,
    output logic signed [SAMPLE_WIDTH-1:0] shape
);

    logic [SAMPLE_WIDTH-1:0] tri_base;

    always_comb begin
        shape    = '0;
        tri_base = {p[SAMPLE_WIDTH-2:0], 1'b0};
        case (wave_sel)
            WAVE_SQUARE: shape = p[SAMPLE_WIDTH-1] ? SQUARE_LO : SQUARE_HI;
            WAVE_SAW:    shape = p ^ SIGN_FLIP;
            // Rising half doubles the slope; falling half mirrors it
            WAVE_TRI:    shape = p[SAMPLE_WIDTH-1] ? (~tri_base ^ SIGN_FLIP)
                                                   : (tri_base ^ SIGN_FLIP);
            default:     shape = '0;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// rtl/tone_generator.sv - phase-accumulator oscillator with 3-stage shape/scale pipeline
module tone_generator #(
    parameter int PHASE_WIDTH  = tone_pkg::PHASE_WIDTH,
    parameter int SAMPLE_WIDTH = tone_pkg::SAMPLE_WIDTH,
    parameter int AMP_WIDTH    = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [PHASE_WIDTH-1:0]  phase_inc_in,
    input  logic                    phase_inc_valid_in,
    input  logic                    sample_tick_in,
    input  logic [1:0]              wave_sel_in,
    input  logic [AMP_WIDTH-1:0]    amplitude_in,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    sample_valid_out,
    input  logic                    sample_ready_in,
    output logic                    phase_wrap_out,
    output logic                    overflow_out
);
    import tone_pkg::*;

    localparam int PROD_WIDTH = SAMPLE_WIDTH + AMP_WIDTH;

    logic [PHASE_WIDTH-1:0] acc, active_inc, pending_inc;
    logic [PHASE_WIDTH:0]   acc_sum;
    logic                   carry;

    logic                   s1_valid;
    wave_sel_t              s1_sel;
    logic [AMP_WIDTH-1:0]   s1_amp;

    logic                          s2_valid;
    logic signed [SAMPLE_WIDTH-1:0] s2_shape;
    logic [AMP_WIDTH-1:0]          s2_amp;

    logic signed [SAMPLE_WIDTH-1:0] shape_c;
    logic signed [PROD_WIDTH-1:0]   shape_ext, amp_ext, prod;
    logic [SAMPLE_WIDTH-1:0]        scaled;

    assign acc_sum = {1'b0, acc} + {1'b0, active_inc};
    assign carry   = acc_sum[PHASE_WIDTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_inc <= '0;
        end else if (phase_inc_valid_in) begin
            pending_inc <= phase_inc_in;
        end
    end

    // Stage 1: accumulate; a new increment is only adopted at a wrap (or from idle)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc            <= '0;
            active_inc     <= '0;
            s1_valid       <= 1'b0;
            s1_sel         <= WAVE_SQUARE;
            s1_amp         <= '0;
            phase_wrap_out <= 1'b0;
        end else begin
            s1_valid       <= sample_tick_in;
            phase_wrap_out <= sample_tick_in & carry;
            if (sample_tick_in) begin
                acc    <= acc_sum[PHASE_WIDTH-1:0];
                s1_sel <= wave_sel_t'(wave_sel_in);
                s1_amp <= amplitude_in;
                if (carry || active_inc == '0) begin
                    active_inc <= pending_inc;
                end
            end
        end
    end

    wave_shaper u_shaper (
        .p        (acc[PHASE_WIDTH-1 -: SAMPLE_WIDTH]),
        .wave_sel (s1_sel),
        .shape    (shape_c)
    );

    // Stage 2: register the shaped value with its captured amplitude
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_shape <= '0;
            s2_amp   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_shape <= shape_c;
                s2_amp   <= s1_amp;
            end
        end
    end

    assign shape_ext = {{AMP_WIDTH{s2_shape[SAMPLE_WIDTH-1]}}, s2_shape};
    assign amp_ext   = {{SAMPLE_WIDTH{1'b0}}, s2_amp};
    assign prod      = shape_ext * amp_ext;
    assign scaled    = SAMPLE_WIDTH'(prod >>> AMP_WIDTH);

    // Stage 3: output register; a fresh sample always wins over a held one
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overflow_out     <= 1'b0;
        end else if (s2_valid) begin
            sample_out       <= scaled;
            sample_valid_out <= 1'b1;
            if (sample_valid_out && !sample_ready_in) begin
                overflow_out <= 1'b1;
            end
        end else if (sample_valid_out && sample_ready_in) begin
            sample_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
// tb/tb_tone_generator.sv - scoreboard bench for tone_generator
module tb_tone_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] phase_inc;
    logic        phase_inc_valid;
    logic        sample_tick;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        phase_wrap;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic signed [15:0] s;
        int                 cyc;
    } exp_t;

    exp_t q[$];

    tone_generator dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .phase_inc_in       (phase_inc),
        .phase_inc_valid_in (phase_inc_valid),
        .sample_tick_in     (sample_tick),
        .wave_sel_in        (wave_sel),
        .amplitude_in       (amplitude),
        .sample_out         (sample_out),
        .sample_valid_out   (sample_valid),
        .sample_ready_in    (sample_ready),
        .phase_wrap_out     (phase_wrap),
        .overflow_out       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sample_valid && sample_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sample: got %0d at cycle %0d, required no sample",
                         $signed(sample_out), cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ($signed(sample_out) != e.s || (e.cyc >= 0 && cyc != e.cyc)) begin
                    bad++;
                    $display("FAIL sample: got %0d at cycle %0d, required %0d at cycle %0d",
                             $signed(sample_out), cyc, e.s, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    task automatic load(input logic [31:0] v);
        phase_inc       = v;
        phase_inc_valid = 1'b1;
        idle(1);
        phase_inc_valid = 1'b0;
    endtask

    // Called 1ns after a rising edge; leaves 1ns after the next one so ticks can be back-to-back
    task automatic tick(input logic [1:0] ws, input logic [7:0] amp,
                        input logic signed [15:0] es, input bit expw,
                        input bit push, input bit timed);
        exp_t e;
        e.s   = es;
        e.cyc = timed ? cyc + 3 : -1;
        if (push) q.push_back(e);
        sample_tick = 1'b1;
        wave_sel    = ws;
        amplitude   = amp;
        idle(1);
        sample_tick = 1'b0;
        chk("phase_wrap", phase_wrap, expw);
    endtask

    task automatic drain();
        idle(6);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; phase_inc = '0; phase_inc_valid = 1'b0; sample_tick = 1'b0;
        wave_sel = 2'd0; amplitude = '0; sample_ready = 1'b1;
        idle(2);
        chk("reset_sample", sample_out, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_wrap", phase_wrap, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b0;

        // Saw at half gain, 2^30 steps; second load must win
        load(32'h8000_0000);
        load(32'h4000_0000);
        tick(2'd1, 8'd128, -16384, 0, 1, 1);
        tick(2'd1, 8'd128,  -8192, 0, 1, 1);
        tick(2'd1, 8'd128,      0, 0, 1, 1);
        tick(2'd1, 8'd128,   8192, 0, 1, 1);
        tick(2'd1, 8'd128, -16384, 1, 1, 1);
        drain();

        // Increment change deferred to the wrap
        do_reset();
        load(32'h4000_0000);
        tick(2'd1, 8'd128, -16384, 0, 1, 1);
        tick(2'd1, 8'd128,  -8192, 0, 1, 1);
        load(32'h8000_0000);
        tick(2'd1, 8'd128,      0, 0, 1, 1);
        tick(2'd1, 8'd128,   8192, 0, 1, 1);
        tick(2'd1, 8'd128, -16384, 1, 1, 1);
        tick(2'd1, 8'd128,      0, 0, 1, 1);
        tick(2'd1, 8'd128, -16384, 1, 1, 1);
        drain();

        // Square at full gain, ticks every cycle
        do_reset();
        load(32'h4000_0000);
        tick(2'd0, 8'd255,  32639, 0, 1, 1);
        tick(2'd0, 8'd255,  32639, 0, 1, 1);
        tick(2'd0, 8'd255, -32640, 0, 1, 1);
        tick(2'd0, 8'd255, -32640, 0, 1, 1);
        tick(2'd0, 8'd255,  32639, 1, 1, 1);
        drain();

        // Triangle, then per-tick wave/amplitude changes in flight
        do_reset();
        load(32'h2000_0000);
        tick(2'd2, 8'd255, -32640, 0, 1, 1);
        tick(2'd2, 8'd255, -16320, 0, 1, 1);
        tick(2'd2, 8'd255,      0, 0, 1, 1);
        tick(2'd2, 8'd255,  16320, 0, 1, 1);
        tick(2'd2, 8'd255,  32639, 0, 1, 1);
        tick(2'd2, 8'd255,  16319, 0, 1, 1);
        tick(2'd3, 8'd255,      0, 0, 1, 1);
        tick(2'd0, 8'd0,        0, 0, 1, 1);
        tick(2'd1, 8'd255, -32640, 1, 1, 1);
        drain();

        // Backpressure: second sample overwrites the first and overflow sticks
        do_reset();
        load(32'h4000_0000);
        sample_ready = 1'b0;
        tick(2'd1, 8'd128, -16384, 0, 0, 0);
        idle(1);
        tick(2'd1, 8'd128,  -8192, 0, 1, 0);
        idle(5);
        chk("held_valid", sample_valid, 1);
        chk("held_sample", $signed(sample_out), -8192);
        chk("overflow_set", overflow, 1);
        sample_ready = 1'b1;
        idle(1);
        chk("valid_after_accept", sample_valid, 0);
        chk("overflow_sticky", overflow, 1);
        drain();

        // Reset right after a tick flushes the pipeline and the increment
        do_reset();
        load(32'h4000_0000);
        tick(2'd1, 8'd128, 0, 0, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("flush_valid", sample_valid, 0);
        chk("flush_sample", sample_out, 0);
        chk("flush_wrap", phase_wrap, 0);
        chk("flush_overflow", overflow, 0);
        idle(5);
        tick(2'd1, 8'd128, -16384, 0, 1, 1);
        tick(2'd1, 8'd128, -16384, 0, 1, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
